// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one request per cycle is granted (round-robin or port-0
// priority); writes pass straight through to memory, reads wait one cycle for data.
module mem_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_bytes,
    input  logic [63:0] req_wdata,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_fetch_addr,
    output logic [3:0]  mem_bytes_to_write,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_fetched_data
);

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        rd_port_q, rd_port_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [1:0]  resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        grant;
    logic        accept;
    logic        g_write;
    logic        g_legal;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_bytes;

    // Arbitration and mux of the granted port's request fields.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = (RR_ENABLE != 0) ? ~last_grant_q : 1'b0;
        end else begin
            grant = req_valid[1];
        end
        accept  = (state_q == IDLE) && (req_valid != 2'b00) && !rst;
        g_write = grant ? req_write[1] : req_write[0];
        g_addr  = grant ? req_addr[63:32] : req_addr[31:0];
        g_wdata = grant ? req_wdata[63:32] : req_wdata[31:0];
        g_bytes = grant ? req_bytes[7:4] : req_bytes[3:0];
        g_legal = (g_bytes == 4'd1) || (g_bytes == 4'd2) || (g_bytes == 4'd4);
    end

    always_comb begin
        req_ready          = 2'b00;
        mem_bytes_to_write = 4'd0;
        mem_write_addr     = 32'd0;
        mem_write_data     = 32'd0;
        mem_fetch_addr     = fetch_addr_q;
        if (accept) begin
            req_ready = grant ? 2'b10 : 2'b01;
            if (g_write && g_legal) begin
                mem_bytes_to_write = g_bytes;
                mem_write_addr     = g_addr;
                mem_write_data     = g_wdata;
            end
            if (!g_write) begin
                mem_fetch_addr = g_addr;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rd_port_d    = rd_port_q;
        fetch_addr_d = fetch_addr_q;
        resp_valid_d = 2'b00;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant;
                    if (g_write) begin
                        resp_valid_d = grant ? 2'b10 : 2'b01;
                        resp_err_d   = !g_legal;
                    end else begin
                        fetch_addr_d = g_addr;
                        rd_port_d    = grant;
                        state_d      = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                // Memory data for the address issued last cycle is valid now.
                resp_rdata_d = mem_fetched_data;
                resp_valid_d = rd_port_q ? 2'b10 : 2'b01;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rd_port_q    <= 1'b0;
            fetch_addr_q <= 32'd0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_port_q    <= rd_port_d;
            fetch_addr_q <= fetch_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model with its own byte memory; a second instance runs fixed priority.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = '0;
    logic [63:0] req_addr = '0;
    logic [7:0]  req_bytes = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_fetch_addr;
    logic [3:0]  mem_bytes_to_write;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_fetched_data = '0;

    logic [1:0]  fp_req_valid = '0;
    logic [1:0]  fp_req_ready;
    logic [1:0]  fp_req_write = '0;
    logic [63:0] fp_req_addr = '0;
    logic [7:0]  fp_req_bytes = '0;
    logic [63:0] fp_req_wdata = '0;
    logic [1:0]  fp_resp_valid;
    logic [31:0] fp_resp_rdata;
    logic        fp_resp_err;
    logic [31:0] fp_mem_fetch_addr;
    logic [3:0]  fp_mem_bytes_to_write;
    logic [31:0] fp_mem_write_addr;
    logic [31:0] fp_mem_write_data;
    logic [31:0] fp_mem_fetched_data = 32'h0;

    always #5 clk = ~clk;

    mem_arbiter #(.RR_ENABLE(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_bytes(req_bytes),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_fetch_addr(mem_fetch_addr),
        .mem_bytes_to_write(mem_bytes_to_write), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_fetched_data(mem_fetched_data)
    );

    mem_arbiter #(.RR_ENABLE(0)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
        .req_write(fp_req_write), .req_addr(fp_req_addr), .req_bytes(fp_req_bytes),
        .req_wdata(fp_req_wdata), .resp_valid(fp_resp_valid), .resp_rdata(fp_resp_rdata),
        .resp_err(fp_resp_err), .mem_fetch_addr(fp_mem_fetch_addr),
        .mem_bytes_to_write(fp_mem_bytes_to_write), .mem_write_addr(fp_mem_write_addr),
        .mem_write_data(fp_mem_write_data), .mem_fetched_data(fp_mem_fetched_data)
    );

    // Environment memory seen by the DUT: writes commit on the edge, reads return next cycle.
    logic [7:0] env_mem [1024];
    always @(posedge clk) begin
        mem_fetched_data <= {env_mem[(mem_fetch_addr + 32'd3) & 32'h3FF],
                             env_mem[(mem_fetch_addr + 32'd2) & 32'h3FF],
                             env_mem[(mem_fetch_addr + 32'd1) & 32'h3FF],
                             env_mem[mem_fetch_addr & 32'h3FF]};
        for (int i = 0; i < 4; i++) begin
            if (i < int'(mem_bytes_to_write))
                env_mem[(mem_write_addr + i) & 32'h3FF] = mem_write_data[8*i +: 8];
        end
    end

    typedef struct packed {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
    } req_t;

    typedef struct packed {
        logic        v;
        logic        port;
        logic        err;
        logic        rd;
        logic [31:0] data;
    } resp_t;

    req_t        p [2];
    logic [7:0]  ref_mem [1024];
    resp_t       q1, q2;
    logic        busy;
    logic        last_g;
    logic [31:0] fetch_hold;
    logic [31:0] exp_rdata;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        grants [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return {ref_mem[(a + 32'd3) & 32'h3FF], ref_mem[(a + 32'd2) & 32'h3FF],
                ref_mem[(a + 32'd1) & 32'h3FF], ref_mem[a & 32'h3FF]};
    endfunction

    task automatic model_reset();
        q1 = '0; q2 = '0; busy = 1'b0; last_g = 1'b1;
        fetch_hold = 32'd0; exp_rdata = 32'd0;
    endtask

    task automatic drive();
        req_valid = {p[1].v, p[0].v};
        req_write = {p[1].w, p[0].w};
        req_addr  = {p[1].a, p[0].a};
        req_bytes = {p[1].b, p[0].b};
        req_wdata = {p[1].d, p[0].d};
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model, check responses.
    task automatic step(output logic acc, output logic g);
        logic legal;
        drive();
        #1;
        acc = !busy && (p[0].v || p[1].v);
        if (p[0].v && p[1].v) g = ~last_g;
        else g = p[1].v;
        legal = (p[g].b == 4'd1) || (p[g].b == 4'd2) || (p[g].b == 4'd4);
        chk("req_ready", req_ready, acc ? (g ? 2'b10 : 2'b01) : 2'b00);
        if (acc && p[g].w && legal) begin
            chk("wr_bytes", mem_bytes_to_write, p[g].b);
            chk("wr_addr", mem_write_addr, p[g].a);
            chk("wr_data", mem_write_data, p[g].d);
        end else begin
            chk("wr_bytes_idle", mem_bytes_to_write, 4'd0);
        end
        if (acc && !p[g].w) fetch_hold = p[g].a;
        chk("fetch_addr", mem_fetch_addr, fetch_hold);
        if (acc) begin
            last_g = g;
            if (p[g].w) begin
                if (legal)
                    for (int i = 0; i < int'(p[g].b); i++)
                        ref_mem[(p[g].a + i) & 32'h3FF] = p[g].d[8*i +: 8];
                q1 = '{v: 1'b1, port: g, err: !legal, rd: 1'b0, data: 32'd0};
            end else begin
                q2 = '{v: 1'b1, port: g, err: 1'b0, rd: 1'b1, data: ref_read(p[g].a)};
            end
        end
        busy = acc && !p[g].w;
        @(posedge clk);
        @(negedge clk);
        if (q1.v && q1.rd) exp_rdata = q1.data;
        chk("resp_valid", resp_valid, q1.v ? (q1.port ? 2'b10 : 2'b01) : 2'b00);
        if (q1.v) chk("resp_err", resp_err, q1.err);
        chk("resp_rdata", resp_rdata, exp_rdata);
        q1 = q2;
        q2 = '0;
    endtask

    task automatic issue(input logic port, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        logic acc, g;
        bit done = 0;
        p[port] = '{v: 1'b1, w: w, a: a, b: b, d: d};
        for (int k = 0; k < 6 && !done; k++) begin
            step(acc, g);
            if (acc && g == port) done = 1;
        end
        chk("issue_accepted", done, 1'b1);
        p[port].v = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        logic acc, g;
        for (int k = 0; k < n; k++) step(acc, g);
    endtask

    initial begin
        logic acc, g;
        p[0] = '0; p[1] = '0;
        model_reset();
        // Requests presented during reset must not be accepted.
        p[0] = '{v: 1'b1, w: 1'b1, a: 32'h100, b: 4'd4, d: 32'h12345678};
        drive();
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_wr_bytes", mem_bytes_to_write, 4'd0);
        chk("rst_wr_addr", mem_write_addr, 32'd0);
        chk("rst_wr_data", mem_write_data, 32'd0);
        chk("rst_fetch_addr", mem_fetch_addr, 32'd0);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Both ports read every cycle: grants alternate starting with port 0.
        p[0] = '{v: 1'b1, w: 1'b0, a: 32'h120, b: 4'd0, d: 32'd0};
        p[1] = '{v: 1'b1, w: 1'b0, a: 32'h124, b: 4'd0, d: 32'd0};
        for (int k = 0; k < 8; k++) begin
            step(acc, g);
            if (acc) grants.push_back(g);
        end
        chk("rr_grant_count", grants.size(), 4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            chk($sformatf("rr_grant_%0d", k), grants[k], k[0]);
        p[0].v = 1'b0; p[1].v = 1'b0;
        idle_steps(2);

        // Full write then read back.
        issue(1'b0, 1'b1, 32'h100, 4'd4, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 32'h100, 4'd0, 32'h0);
        idle_steps(2);
        chk("wr_rd_0x100", resp_rdata, 32'hFFFF_FFFF);

        // Illegal byte count leaves memory untouched.
        issue(1'b1, 1'b1, 32'h104, 4'd4, 32'h1122_3344);
        issue(1'b1, 1'b1, 32'h104, 4'd3, 32'hDEAD_BEEF);
        issue(1'b0, 1'b0, 32'h104, 4'd0, 32'h0);
        idle_steps(2);
        chk("illegal_unchanged", resp_rdata, 32'h1122_3344);

        // Unaligned write overlapping an aligned word.
        issue(1'b0, 1'b1, 32'h100, 4'd4, 32'h0000_0000);
        issue(1'b1, 1'b1, 32'h101, 4'd4, 32'hAABB_CCDD);
        issue(1'b0, 1'b0, 32'h100, 4'd7, 32'h0);
        idle_steps(2);
        chk("unaligned_rd", resp_rdata, 32'hBBCC_DD00);

        // Random traffic; an unaccepted request is held unchanged.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p[i].v && $urandom_range(0, 1) == 1) begin
                    p[i].v = 1'b1;
                    p[i].w = 1'($urandom_range(0, 1));
                    p[i].a = 32'h100 + $urandom_range(0, 63);
                    case ($urandom_range(0, 5))
                        0: p[i].b = 4'd1;
                        1: p[i].b = 4'd2;
                        2: p[i].b = 4'd3;
                        3: p[i].b = 4'($urandom_range(5, 15));
                        default: p[i].b = 4'd4;
                    endcase
                    p[i].d = $urandom;
                end
            end
            step(acc, g);
            if (acc) p[g].v = 1'b0;
        end
        p[0].v = 1'b0; p[1].v = 1'b0;
        idle_steps(3);

        // Reset during the read wait drops the pending response.
        issue(1'b0, 1'b0, 32'h108, 4'd0, 32'h0);
        rst = 1'b1;
        drive();
        #1;
        chk("mid_rst_req_ready", req_ready, 2'b00);
        chk("mid_rst_resp_valid", resp_valid, 2'b00);
        chk("mid_rst_resp_err", resp_err, 1'b0);
        chk("mid_rst_resp_rdata", resp_rdata, 32'd0);
        chk("mid_rst_fetch_addr", mem_fetch_addr, 32'd0);
        chk("mid_rst_wr_bytes", mem_bytes_to_write, 4'd0);
        chk("mid_rst_wr_addr", mem_write_addr, 32'd0);
        chk("mid_rst_wr_data", mem_write_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        p[1] = '{v: 1'b1, w: 1'b1, a: 32'h110, b: 4'd2, d: 32'h0000_BEEF};
        step(acc, g);
        chk("post_rst_accept", acc, 1'b1);
        p[1].v = 1'b0;
        idle_steps(3);

        // Fixed priority: port 1 never granted while port 0 keeps requesting.
        fp_req_valid = 2'b11;
        fp_req_write = 2'b11;
        fp_req_addr  = {32'h200, 32'h100};
        fp_req_bytes = 8'h44;
        fp_req_wdata = {32'h2222_2222, 32'h1111_1111};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("fp_wr_ready", fp_req_ready, 2'b01);
            chk("fp_wr_addr", fp_mem_write_addr, 32'h100);
            @(negedge clk);
        end
        fp_req_write = 2'b00;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fp_rd_ready", fp_req_ready, k[0] ? 2'b00 : 2'b01);
            @(negedge clk);
        end
        fp_req_valid = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RR_ENABLE, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 0 winning.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  2  per-port request valid; bit i = port i.
REQ-005 req_ready  output  2  per-port accept; combinational, at most one bit high.
REQ-006 req_write  input  2  per-port: 1 = write, 0 = read.
REQ-007 req_addr  input  64  per-port byte address; port i at bits [32i+31:32i].
REQ-008 req_bytes  input  8  per-port write byte count; port i at bits [4i+3:4i]; legal values 1, 2, 4.
REQ-009 req_wdata  input  64  per-port write data; little-endian, byte 0 = bits [7:0].
REQ-010 resp_valid  output  2  per-port one-cycle completion pulse.
REQ-011 resp_rdata  output  32  read data, shared, qualified by resp_valid.
REQ-012 resp_err  output  1  illegal-request flag, qualified by resp_valid.
REQ-013 mem_fetch_addr  output  32  memory read address; data returns on mem_fetched_data one cycle later.
REQ-014 mem_bytes_to_write  output  4  memory write byte count; 0 = no-op; commits on rising edge.
REQ-015 mem_write_addr  output  32  memory write byte address; unaligned addresses allowed.
REQ-016 mem_write_data  output  32  memory write data.
REQ-017 mem_fetched_data  input  32  memory read data.

Function
REQ-018 The FSM SHALL have two states: IDLE and READ_WAIT.
REQ-019 In IDLE with any req_valid high, the block SHALL grant exactly one port; req_ready of the granted port is high that cycle and the request is accepted.
REQ-020 In READ_WAIT, req_ready SHALL be 2'b00.
REQ-021 Arbitration with RR_ENABLE=1 SHALL grant the port not equal to last_grant when both ports are valid, otherwise the single valid port.
REQ-022 last_grant SHALL update to the granted port on every accept.
REQ-023 Arbitration with RR_ENABLE=0 SHALL always grant port 0 when both ports are valid.
REQ-024 On an accepted legal write in cycle T, the block SHALL drive mem_write_addr, mem_write_data and mem_bytes_to_write from the granted port in cycle T (combinational pass-through).
REQ-025 A legal write accepted in T SHALL assert resp_valid[g]=1 and resp_err=0 in T+1, and the FSM SHALL remain in IDLE.
REQ-026 mem_bytes_to_write SHALL be 0 in every cycle without an accepted legal write.
REQ-027 A write with req_bytes not in {1,2,4} SHALL be accepted with mem_bytes_to_write=0, then resp_valid[g]=1 and resp_err=1 in T+1.
REQ-028 On an accepted read in cycle T, the block SHALL drive mem_fetch_addr=req_addr[g] in T, capture the address and port into registers, and enter READ_WAIT.
REQ-029 Reads SHALL ignore req_bytes.
REQ-030 From T+1 to the next accepted read, mem_fetch_addr SHALL hold the registered read address.
REQ-031 In READ_WAIT (T+1), the block SHALL register mem_fetched_data into resp_rdata and return to IDLE.
REQ-032 A read accepted in T SHALL assert resp_valid[g]=1 and resp_err=0 in T+2.
REQ-033 Latency SHALL be write 1 cycle and read 2 cycles.
REQ-034 Throughput SHALL be 1 write per cycle and 1 read per 2 cycles.
REQ-035 IDLE SHALL accept a new request in the same cycle a response is asserted.
REQ-036 resp_rdata SHALL hold its value until the next read capture.
REQ-037 A requester SHALL hold valid, addr, bytes and wdata stable until its ready is seen; the block does not register unaccepted requests.

Reset
REQ-038 While rst=1 the block SHALL force: FSM=IDLE, last_grant=1 (port 0 wins first tie), req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_fetch_addr=0, mem_bytes_to_write=0, mem_write_addr=0, mem_write_data=0.
REQ-039 Reset asserted during READ_WAIT SHALL drop the pending read; no resp_valid follows deassertion.
REQ-040 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-041 Port 0 write addr 0x100, data 0xFFFF_FFFF, bytes 4, then port 0 read 0x100 -> mem_bytes_to_write=4 in accept cycle; resp_valid=2'b01 next cycle; read resp_rdata=0xFFFF_FFFF two cycles after read accept.
REQ-042 Both ports request reads every cycle for 8 cycles after reset -> grants alternate 0,1,0,1; each resp_valid arrives 2 cycles after its accept; req_ready=0 in every READ_WAIT cycle.
REQ-043 RR_ENABLE=0, both ports request continuously -> port 1 never granted; port 0 served every eligible cycle.
REQ-044 Write bytes 3 to 0x104 -> mem_bytes_to_write stays 0; resp_valid pulses with resp_err=1; subsequent read of 0x104 returns the prior contents unchanged.
REQ-045 Write 0x0000_0000 (bytes 4) to 0x100, then write 0xAABB_CCDD (bytes 4) to 0x101, then read 0x100 -> resp_rdata=0xBBCC_DD00.
REQ-046 Assert rst in the cycle after a read accept -> no resp_valid after release; all outputs at reset values; a new request is accepted on the first post-reset cycle.
